// File: rtl/tlul_host_arb_adapter.sv
// Multi-host TL-UL adapter: round-robin arbitration of core-style
// req/gnt/rvalid channels onto one TL-UL host port, routed by source.
package tlul_pkg;
  parameter int TL_AW  = 32;
  parameter int TL_DW  = 32;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_DBW = TL_DW / 8;

  parameter logic [2:0] PutFullData    = 3'h0;
  parameter logic [2:0] PutPartialData = 3'h1;
  parameter logic [2:0] Get            = 3'h4;
  parameter logic [2:0] AccessAck      = 3'h0;
  parameter logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arb_adapter
  import tlul_pkg::*;
#(
  parameter int NumHosts = 2,
  parameter int MaxReqs  = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumHosts-1:0]    req_i,
  output logic [NumHosts-1:0]    gnt_o,
  input  logic [NumHosts*AW-1:0] addr_i,
  input  logic [NumHosts-1:0]    we_i,
  input  logic [NumHosts*DW-1:0] wdata_i,
  input  logic [NumHosts*DW/8-1:0] be_i,
  output logic [NumHosts-1:0]    valid_o,
  output logic [DW-1:0]          rdata_o,
  output logic                   err_o,
  output tl_h2d_t                tl_o,
  input  tl_d2h_t                tl_i,
  output logic                   unexp_o,
  output logic                   busy_o
);

  localparam int HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int SW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam int CW = $clog2(MaxReqs + 1);
  localparam int BW = DW / 8;

  logic [CW-1:0] out_cnt [NumHosts];
  logic [SW-1:0] wr_ptr  [NumHosts];
  logic [HW-1:0] rr_ptr;

  logic          locked;
  logic [HW-1:0] lk_host;
  logic [AW-1:0] lk_addr;
  logic          lk_we;
  logic [DW-1:0] lk_wdata;
  logic [BW-1:0] lk_be;
  logic [SW-1:0] lk_slot;

  logic          pick_vld;
  logic [HW-1:0] pick;
  logic          a_vld;
  logic          hs;
  logic [HW-1:0] cur_host;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  logic [DW-1:0] cur_wdata;
  logic [BW-1:0] cur_be;
  logic [SW-1:0] cur_slot;
  logic [HW-1:0] d_host;
  logic [NumHosts-1:0] resp_vec;
  logic          any_out;

  // Round-robin search for the first eligible host starting at rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NumHosts; i++) begin
      idx = (int'(rr_ptr) + i) % NumHosts;
      if (!pick_vld && req_i[idx] &&
          out_cnt[idx] < CW'(MaxReqs)) begin
        pick_vld = 1'b1;
        pick     = HW'(idx);
      end
    end
  end

  // Present either the held (locked) beat or the freshly chosen host.
  always_comb begin
    cur_host  = locked ? lk_host : pick;
    cur_addr  = locked ? lk_addr : addr_i[int'(pick)*AW +: AW];
    cur_we    = locked ? lk_we : we_i[pick];
    cur_wdata = locked ? lk_wdata : wdata_i[int'(pick)*DW +: DW];
    cur_be    = locked ? lk_be : be_i[int'(pick)*BW +: BW];
    cur_slot  = locked ? lk_slot : wr_ptr[pick];
    a_vld     = !rst_i && (locked || pick_vld);
    hs        = a_vld && tl_i.a_ready;
    for (int h = 0; h < NumHosts; h++) begin
      gnt_o[h] = hs && (cur_host == HW'(h));
    end
  end

  // TL-UL A channel encoding; D channel is always accepted.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_vld;
    tl_o.a_size    = 2'd2;
    tl_o.a_address = TL_AW'({cur_addr[AW-1:2], 2'b00});
    tl_o.a_source  = TL_AIW'({cur_host, cur_slot});
    tl_o.a_data    = TL_DW'(cur_wdata);
    if (!cur_we) begin
      tl_o.a_opcode = Get;
      tl_o.a_mask   = '1;
    end else begin
      tl_o.a_opcode = (&cur_be) ? PutFullData : PutPartialData;
      tl_o.a_mask   = TL_DBW'(cur_be);
    end
    tl_o.d_ready   = 1'b1;
  end

  // Route a D beat to its host only if that host has something outstanding.
  always_comb begin
    d_host  = tl_i.d_source[SW +: HW];
    any_out = 1'b0;
    for (int h = 0; h < NumHosts; h++) begin
      resp_vec[h] = tl_i.d_valid && (d_host == HW'(h)) &&
                    (out_cnt[h] != '0);
      any_out     = any_out || (out_cnt[h] != '0);
    end
    busy_o = a_vld || any_out;
  end

  // Registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      unexp_o <= 1'b0;
    end else begin
      valid_o <= resp_vec;
      unexp_o <= tl_i.d_valid && !(|resp_vec);
      if (|resp_vec) begin
        rdata_o <= tl_i.d_data[DW-1:0];
        err_o   <= tl_i.d_error;
      end
    end
  end

  // Per-host outstanding counters and source slot pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int h = 0; h < NumHosts; h++) begin
        out_cnt[h] <= '0;
        wr_ptr[h]  <= '0;
      end
    end else begin
      for (int h = 0; h < NumHosts; h++) begin
        if (gnt_o[h] && !resp_vec[h]) begin
          out_cnt[h] <= out_cnt[h] + 1'b1;
        end else if (!gnt_o[h] && resp_vec[h]) begin
          out_cnt[h] <= out_cnt[h] - 1'b1;
        end
        if (gnt_o[h]) begin
          wr_ptr[h] <= (MaxReqs == 1) ? '0 : wr_ptr[h] + 1'b1;
        end
      end
    end
  end

  // Lock a stalled A beat and advance the round-robin pointer on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lk_host  <= '0;
      lk_addr  <= '0;
      lk_we    <= 1'b0;
      lk_wdata <= '0;
      lk_be    <= '0;
      lk_slot  <= '0;
    end else if (hs) begin
      locked <= 1'b0;
      rr_ptr <= HW'((int'(cur_host) + 1) % NumHosts);
    end else if (a_vld && !locked) begin
      locked   <= 1'b1;
      lk_host  <= cur_host;
      lk_addr  <= cur_addr;
      lk_we    <= cur_we;
      lk_wdata <= cur_wdata;
      lk_be    <= cur_be;
      lk_slot  <= cur_slot;
    end
  end

endmodule
